// File: rtl/param_fifo_pkg.sv
// Shared definitions for param_fifo: read-mode constants and pointer sizing.
package param_fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Address bits plus one wrap bit, so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  wr_clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  // NOTE: the storage array has no reset so it can map onto block RAM; only
  // the read register is cleared.
  always_ff @(posedge wr_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge wr_clk) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/param_fifo.sv
// Single-clock parameterised FIFO with standard or first-word-fall-through
// read, registered status flags and occupancy count.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_DEPTH    = 128,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DATA_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                             wr_clk,
  input  logic                             reset_n,
  input  logic                             wr_en_i,
  input  logic [DATA_WIDTH-1:0]            wr_data_i,
  input  logic                             rd_en_i,
  output logic [DATA_WIDTH-1:0]            rd_data_o,
  output logic                             rd_valid_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic                             almost_full_o,
  output logic                             almost_empty_o,
  output logic                             overflow_o,
  output logic                             underflow_o,
  output logic [ptr_width(DATA_DEPTH)-1:0] count_o
);

  localparam int PW      = ptr_width(DATA_DEPTH);
  localparam int AW      = PW - 1;
  localparam bit IS_FWFT = (FWFT == FWFT_ON);

  typedef logic [PW-1:0] ptr_t;

  ptr_t wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic wr_acc, rd_acc, rd_legal, fetch, out_load, mem_empty;
  logic ram_vld, ram_vld_nxt, out_vld, out_vld_nxt, std_vld;
  logic full_nxt, empty_nxt;
  logic [DATA_WIDTH-1:0] ram_q, out_reg;

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(AW)
  ) u_ram (
    .wr_clk (wr_clk),
    .reset_n(reset_n),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr[AW-1:0]),
    .wr_data(wr_data_i),
    .rd_en  (fetch),
    .rd_addr(rd_ptr[AW-1:0]),
    .rd_data(ram_q)
  );

  // In FWFT mode a word moves memory -> RAM read register (ram_vld) ->
  // output register (out_vld); both stages count as stored words.
  // NOTE: every always_comb output gets a default first so no path can infer
  // a latch.
  always_comb begin
    mem_empty   = (wr_ptr == rd_ptr);
    wr_acc      = wr_en_i && !full_o;
    rd_legal    = IS_FWFT ? out_vld : !empty_o;
    rd_acc      = rd_en_i && rd_legal;
    out_load    = IS_FWFT && ram_vld && (!out_vld || rd_acc);
    fetch       = IS_FWFT ? (!mem_empty && (!ram_vld || out_load)) : rd_acc;
    wr_ptr_nxt  = wr_ptr + ptr_t'(wr_acc);
    rd_ptr_nxt  = rd_ptr + ptr_t'(fetch);
    ram_vld_nxt = IS_FWFT && (fetch || (ram_vld && !out_load));
    out_vld_nxt = IS_FWFT && (out_load || (out_vld && !rd_acc));
    count_nxt   = (wr_ptr_nxt - rd_ptr_nxt) + ptr_t'(ram_vld_nxt) + ptr_t'(out_vld_nxt);
    if (IS_FWFT) begin
      full_nxt  = (count_nxt == ptr_t'(DATA_DEPTH));
      empty_nxt = !out_vld_nxt;
    end else begin
      full_nxt  = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                  (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    end
  end

  always_ff @(posedge wr_clk) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ram_vld        <= 1'b0;
      out_vld        <= 1'b0;
      out_reg        <= '0;
      std_vld        <= 1'b0;
      count_o        <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      rd_ptr         <= rd_ptr_nxt;
      ram_vld        <= ram_vld_nxt;
      out_vld        <= out_vld_nxt;
      if (out_load) out_reg <= ram_q;
      std_vld        <= !IS_FWFT && rd_acc;
      count_o        <= count_nxt;
      full_o         <= full_nxt;
      empty_o        <= empty_nxt;
      almost_full_o  <= (count_nxt >= ptr_t'(AFULL_THRESH));
      almost_empty_o <= (count_nxt <= ptr_t'(AEMPTY_THRESH));
      overflow_o     <= wr_en_i && full_o;
      underflow_o    <= rd_en_i && !rd_legal;
    end
  end

  assign rd_valid_o = IS_FWFT ? out_vld : std_vld;
  assign rd_data_o  = IS_FWFT ? out_reg : ram_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed scoreboard bench for param_fifo: one standard-mode and one
// FWFT-mode instance sharing clock and reset.
module tb_param_fifo;
  import param_fifo_pkg::*;

  localparam int DW = 8;
  localparam int DD = 8;
  localparam int AF = 6;
  localparam int AE = 2;
  localparam int CW = ptr_width(DD);

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic          s_wr_en = 1'b0, s_rd_en = 1'b0;
  logic [DW-1:0] s_wr_data = '0, s_rd_data;
  logic          s_rd_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
  logic [CW-1:0] s_count;

  logic          f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [DW-1:0] f_wr_data = '0, f_rd_data;
  logic          f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [CW-1:0] f_count;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] sq[$];
  logic [DW-1:0] fq[$];
  int            s_cnt = 0;
  int            f_cnt = 0;
  logic [DW-1:0] s_last = '0;

  always #5 clk = ~clk;

  param_fifo #(
    .DATA_WIDTH(DW), .DATA_DEPTH(DD), .FWFT(FWFT_OFF),
    .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) u_std (
    .wr_clk(clk), .reset_n(reset_n),
    .wr_en_i(s_wr_en), .wr_data_i(s_wr_data), .rd_en_i(s_rd_en),
    .rd_data_o(s_rd_data), .rd_valid_o(s_rd_valid),
    .full_o(s_full), .empty_o(s_empty),
    .almost_full_o(s_afull), .almost_empty_o(s_aempty),
    .overflow_o(s_ovf), .underflow_o(s_unf), .count_o(s_count)
  );

  param_fifo #(
    .DATA_WIDTH(DW), .DATA_DEPTH(DD), .FWFT(FWFT_ON),
    .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) u_fwft (
    .wr_clk(clk), .reset_n(reset_n),
    .wr_en_i(f_wr_en), .wr_data_i(f_wr_data), .rd_en_i(f_rd_en),
    .rd_data_o(f_rd_data), .rd_valid_o(f_rd_valid),
    .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_afull), .almost_empty_o(f_aempty),
    .overflow_o(f_ovf), .underflow_o(f_unf), .count_o(f_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the inputs about to be sampled, then
  // compare every output 1 time unit after the edge.
  task automatic tick();
    bit s_wa, s_ra, s_ov, s_un, f_wa, f_pop, f_ov, f_un;
    logic [DW-1:0] f_exp;
    s_wa = 0; s_ra = 0; s_ov = 0; s_un = 0;
    f_wa = 0; f_pop = 0; f_ov = 0; f_un = 0;
    if (!reset_n) begin
      s_cnt = 0; f_cnt = 0; s_last = '0;
      sq.delete(); fq.delete();
    end else begin
      s_wa = s_wr_en && (s_cnt < DD);
      s_ra = s_rd_en && (s_cnt > 0);
      s_ov = s_wr_en && (s_cnt == DD);
      s_un = s_rd_en && (s_cnt == 0);
      if (s_wa) sq.push_back(s_wr_data);
      if (s_ra) s_last = sq.pop_front();
      s_cnt = s_cnt + int'(s_wa) - int'(s_ra);

      f_wa  = f_wr_en && (f_cnt < DD);
      f_pop = f_rd_en && f_rd_valid;
      f_ov  = f_wr_en && (f_cnt == DD);
      f_un  = f_rd_en && !f_rd_valid;
      if (f_pop) begin
        check("f_pop_has_word", 32'(fq.size() > 0), 32'd1);
        if (fq.size() > 0) begin
          f_exp = fq.pop_front();
          check("f_pop_data", 32'(f_rd_data), 32'(f_exp));
        end
      end
      if (f_wa) fq.push_back(f_wr_data);
      f_cnt = f_cnt + int'(f_wa) - int'(f_pop);
    end

    @(posedge clk);
    #1;

    check("s_valid",     32'(s_rd_valid), 32'(s_ra));
    check("s_data",      32'(s_rd_data),  32'(s_last));
    check("s_count",     32'(s_count),    32'(s_cnt));
    check("s_full",      32'(s_full),     32'(s_cnt == DD));
    check("s_empty",     32'(s_empty),    32'(s_cnt == 0));
    check("s_afull",     32'(s_afull),    32'(s_cnt >= AF));
    check("s_aempty",    32'(s_aempty),   32'(s_cnt <= AE));
    check("s_overflow",  32'(s_ovf),      32'(s_ov));
    check("s_underflow", 32'(s_unf),      32'(s_un));

    check("f_count",     32'(f_count),    32'(f_cnt));
    check("f_full",      32'(f_full),     32'(f_cnt == DD));
    check("f_afull",     32'(f_afull),    32'(f_cnt >= AF));
    check("f_aempty",    32'(f_aempty),   32'(f_cnt <= AE));
    check("f_overflow",  32'(f_ovf),      32'(f_ov));
    check("f_underflow", 32'(f_unf),      32'(f_un));
    check("f_empty_inv", 32'(f_empty),    32'(!f_rd_valid));
    if (!reset_n) begin
      check("f_valid_rst", 32'(f_rd_valid), 32'd0);
      check("f_data_rst",  32'(f_rd_data),  32'd0);
    end
  endtask

  initial begin
    // Reset
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    // Standard mode: fill 0x01..0x08, then one write too many
    s_wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_wr_data = 8'(i);
      tick();
    end
    check("s_full_after_8", 32'(s_full), 32'd1);
    s_wr_data = 8'h09;
    tick();
    check("s_ovf_9th", 32'(s_ovf), 32'd1);
    s_wr_en = 1'b0;
    tick();
    check("s_ovf_one_cycle", 32'(s_ovf), 32'd0);

    // Drain in order, data one cycle after each read
    s_rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("s_drain_data", 32'(s_rd_data), 32'(i));
    end
    s_rd_en = 1'b0;
    check("s_empty_after_drain", 32'(s_empty), 32'd1);
    tick();

    // Thresholds
    s_wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_wr_data = 8'(8'h10 + i);
      tick();
      check("s_afull_edge", 32'(s_afull), 32'(i == 5));
    end
    s_wr_en = 1'b0;
    s_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s_aempty_edge", 32'(s_aempty), 32'(i == 3));
    end
    s_rd_en = 1'b0;
    tick();

    // Simultaneous access at count 4 for 20 cycles (pointers wrap)
    s_wr_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_wr_data = 8'(8'h30 + i);
      tick();
    end
    check("s_count_4", 32'(s_count), 32'd4);
    s_rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_wr_data = 8'(8'h40 + i);
      tick();
      check("s_count_steady", 32'(s_count), 32'd4);
    end
    s_rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_wr_data = 8'(8'h60 + i);
      tick();
    end
    check("s_full_again", 32'(s_full), 32'd1);

    // Full + read + write: write rejected
    s_rd_en = 1'b1;
    s_wr_data = 8'h77;
    tick();
    check("s_full_rw_ovf", 32'(s_ovf), 32'd1);
    check("s_full_rw_count", 32'(s_count), 32'd7);
    s_wr_en = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("s_empty_again", 32'(s_empty), 32'd1);

    // Empty + read + write: read rejected, write accepted
    s_wr_en = 1'b1;
    s_wr_data = 8'h5A;
    tick();
    check("s_empty_rw_unf", 32'(s_unf), 32'd1);
    check("s_empty_rw_count", 32'(s_count), 32'd1);
    s_wr_en = 1'b0;
    tick();
    check("s_empty_rw_data", 32'(s_rd_data), 32'h5A);
    s_rd_en = 1'b0;
    tick();

    // Reset mid-operation at count 5
    s_wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_wr_data = 8'(8'h80 + i);
      tick();
    end
    s_wr_en = 1'b0;
    check("s_count_5", 32'(s_count), 32'd5);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("s_rst_count", 32'(s_count), 32'd0);
    check("s_rst_empty", 32'(s_empty), 32'd1);
    check("s_rst_aempty", 32'(s_aempty), 32'd1);
    check("s_rst_valid", 32'(s_rd_valid), 32'd0);
    check("s_rst_data", 32'(s_rd_data), 32'd0);
    s_wr_en = 1'b1;
    s_wr_data = 8'h3C;
    tick();
    s_wr_en = 1'b0;
    s_rd_en = 1'b1;
    tick();
    check("s_after_rst_data", 32'(s_rd_data), 32'h3C);
    check("s_after_rst_valid", 32'(s_rd_valid), 32'd1);
    s_rd_en = 1'b0;
    tick();

    // FWFT: single word falls through two edges after the write
    f_wr_en = 1'b1;
    f_wr_data = 8'hA5;
    tick();
    f_wr_en = 1'b0;
    check("f_a5_n_valid", 32'(f_rd_valid), 32'd0);
    check("f_a5_n_count", 32'(f_count), 32'd1);
    tick();
    check("f_a5_n1_valid", 32'(f_rd_valid), 32'd0);
    tick();
    check("f_a5_n2_valid", 32'(f_rd_valid), 32'd1);
    check("f_a5_n2_data", 32'(f_rd_data), 32'hA5);
    check("f_a5_n2_empty", 32'(f_empty), 32'd0);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    check("f_pop_valid", 32'(f_rd_valid), 32'd0);
    check("f_pop_empty", 32'(f_empty), 32'd1);
    check("f_pop_count", 32'(f_count), 32'd0);

    // FWFT: back-to-back pops present the next word each cycle
    f_wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_wr_data = 8'(8'hB0 + i);
      tick();
    end
    f_wr_en = 1'b0;
    tick();
    tick();
    f_rd_en = 1'b1;
    tick();
    check("f_stream_v1", 32'(f_rd_valid), 32'd1);
    check("f_stream_d1", 32'(f_rd_data), 32'hB1);
    tick();
    check("f_stream_v2", 32'(f_rd_valid), 32'd1);
    check("f_stream_d2", 32'(f_rd_data), 32'hB2);
    tick();
    check("f_stream_v3", 32'(f_rd_valid), 32'd0);
    f_rd_en = 1'b0;

    // FWFT: fill including the output register, overflow, bounded drain
    f_wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f_wr_data = 8'(8'hC0 + i);
      tick();
    end
    check("f_full_at_8", 32'(f_full), 32'd1);
    f_wr_data = 8'hCF;
    tick();
    check("f_ovf_9th", 32'(f_ovf), 32'd1);
    f_wr_en = 1'b0;
    tick();
    tick();
    f_rd_en = 1'b1;
    for (int k = 0; k < 12 && f_rd_valid; k++) tick();
    check("f_drain_done", 32'(f_rd_valid), 32'd0);
    check("f_queue_empty", 32'(fq.size()), 32'd0);
    tick();
    check("f_underflow_pulse", 32'(f_unf), 32'd1);
    f_rd_en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
